// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master burst arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational 2-way round-robin picker. On a tie the master
// that was not granted last wins; otherwise the single requester wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_gnt,
    output master_id_t winner,
    output logic       any
);

    // Pick a winner among the active requesters.
    always_comb begin
        any    = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between two burst masters,
// sequencing fixed-length line bursts (one word per mem_ready handshake)
// with round-robin fairness.
// Optional build macro MEM_ARB_TIMEOUT_EN: abort a burst after
// TIMEOUT_CYCLES cycles without mem_ready and pulse err with done.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BURST_LEN      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m0_req,
    input  logic                         m0_we,
    input  logic [WIDTH-1:0]             m0_addr,
    input  logic [WIDTH-1:0]             m0_wdata,
    input  logic                         m1_req,
    input  logic                         m1_we,
    input  logic [WIDTH-1:0]             m1_addr,
    input  logic [WIDTH-1:0]             m1_wdata,
    output logic                         m0_gnt,
    output logic                         m1_gnt,
    output logic [$clog2(BURST_LEN)-1:0] beat,
    output logic [WIDTH-1:0]             rdata,
    output logic                         m0_rvalid,
    output logic                         m1_rvalid,
    output logic                         m0_done,
    output logic                         m1_done,
    output logic                         err,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [WIDTH-1:0]             mem_addr,
    output logic [WIDTH-1:0]             mem_wdata,
    input  logic                         mem_ready,
    input  logic [WIDTH-1:0]             mem_rdata
);

    localparam int unsigned BEAT_W   = $clog2(BURST_LEN);
    localparam int unsigned OFF_BITS = $clog2(BURST_LEN * BYTES_PER_WORD);
    localparam logic [WIDTH-1:0] BASE_MASK = ~((WIDTH'(1) << OFF_BITS) - WIDTH'(1));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    arb_state_t       state;
    master_id_t       id;
    master_id_t       last_gnt;
    master_id_t       winner;
    logic             any;
    logic             we_q;
    logic [WIDTH-1:0] base;
    logic             timeout;
    logic             rd_fire;

    mem_arb_rr u_rr (
        .req      ({m1_req, m0_req}),
        .last_gnt (last_gnt),
        .winner   (winner),
        .any      (any)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] to_cnt;

    // Count consecutive BURST cycles without a memory handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state != BURST || mem_ready) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign timeout = (state == BURST) && !mem_ready &&
                     (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    // Arbitration FSM: grant, beat sequencing, done/err pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            id       <= 1'b0;
            last_gnt <= 1'b1;
            we_q     <= 1'b0;
            base     <= '0;
            beat     <= '0;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            err      <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        id     <= winner;
                        we_q   <= winner ? m1_we : m0_we;
                        base   <= (winner ? m1_addr : m0_addr) & BASE_MASK;
                        beat   <= '0;
                        m0_gnt <= !winner;
                        m1_gnt <= winner;
                        state  <= BURST;
                    end
                end
                BURST: begin
                    // Done/gnt are registered on the way into DONE so the
                    // pulse and the dropped grant appear in the DONE cycle.
                    if (timeout || (mem_ready && beat == LAST_BEAT)) begin
                        state   <= DONE;
                        beat    <= '0;
                        m0_gnt  <= 1'b0;
                        m1_gnt  <= 1'b0;
                        m0_done <= !id;
                        m1_done <= id;
                        err     <= timeout;
                    end else if (mem_ready) begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                DONE: begin
                    last_gnt <= id;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req   = (state == BURST);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? base + WIDTH'(beat) * WIDTH'(BYTES_PER_WORD) : '0;
    assign mem_wdata = mem_req ? (id ? m1_wdata : m0_wdata) : '0;
    assign rd_fire   = mem_req && !we_q && mem_ready;
    assign m0_rvalid = rd_fire && !id;
    assign m1_rvalid = rd_fire && id;
    assign rdata     = rd_fire ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Build with
// +define+MEM_ARB_TIMEOUT_EN to exercise the burst-timeout variant.
module tb_mem_arbiter;

    localparam int W  = 32;
    localparam int BL = 4;
    localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk, rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [W-1:0]  m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_done, m1_done, err;
    logic [1:0]    beat;
    logic [W-1:0]  rdata;
    logic          mem_req, mem_we, mem_ready;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(
        .WIDTH          (W),
        .BURST_LEN      (BL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .beat      (beat),
        .rdata     (rdata),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_done   (m0_done),
        .m1_done   (m1_done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: who owns the port, how many words it has moved,
    // whose completion is being announced, and who was served last.
    int          owner;
    int          words;
    int          pend;
    int          stall;
    int          last;
    bit          perr;
    bit          mwe;
    logic [W-1:0] mbase;

    typedef struct {
        logic        req0;
        logic        ready;
        logic [31:0] rd;
        logic        gnt0;
        logic [31:0] addr;
        logic        rvalid0;
        logic        done0;
        logic [1:0]  bt;
    } vec_t;
    vec_t tbl[8];

    int order[4];
    int ng, beats, t_done, t_gnt, bc, gcnt, rv1, tg, te, td;
    bit seen, prevg, reached;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = -1; words = 0; pend = -1; stall = 0;
        last  = 1;  perr  = 0; mwe  = 0;  mbase = '0;
    endtask

    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else if (pend >= 0) begin
            last = pend; pend = -1; perr = 0;
        end else if (owner >= 0) begin
            if (mem_ready) begin
                words++; stall = 0;
                if (words == BL) begin pend = owner; owner = -1; words = 0; end
            end else begin
                stall++;
                if (TO_EN && stall == TO) begin pend = owner; perr = 1; owner = -1; words = 0; end
            end
        end else if (m0_req || m1_req) begin
            if (m0_req && m1_req) owner = 1 - last;
            else owner = m1_req ? 1 : 0;
            words = 0; stall = 0;
            mwe   = (owner == 1) ? m1_we : m0_we;
            mbase = ((owner == 1) ? m1_addr : m0_addr) & ~(32'(BL * 4) - 32'd1);
        end
    endtask

    task automatic model_compare();
        bit act, rv;
        act = (owner >= 0);
        rv  = act && !mwe && mem_ready;
        check("m0_gnt",    32'(m0_gnt),    32'(owner == 0));
        check("m1_gnt",    32'(m1_gnt),    32'(owner == 1));
        check("beat",      32'(beat),      act ? 32'(words) : 32'd0);
        check("mem_req",   32'(mem_req),   32'(act));
        check("mem_we",    32'(mem_we),    32'(act && mwe));
        check("mem_addr",  mem_addr,       act ? mbase + 32'(words * 4) : 32'd0);
        check("mem_wdata", mem_wdata,      act ? ((owner == 1) ? m1_wdata : m0_wdata) : 32'd0);
        check("m0_rvalid", 32'(m0_rvalid), 32'(rv && owner == 0));
        check("m1_rvalid", 32'(m1_rvalid), 32'(rv && owner == 1));
        check("rdata",     rdata,          rv ? mem_rdata : 32'd0);
        check("m0_done",   32'(m0_done),   32'(pend == 0));
        check("m1_done",   32'(m1_done),   32'(pend == 1));
        check("err",       32'(err),       32'(pend >= 0 && perr));
    endtask

    task automatic sample();
        @(negedge clk);
        cyc++;
        model_compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            sample();
            ok = !mem_req && !m0_gnt && !m1_gnt && !m0_done && !m1_done;
            advance();
        end
        check("wait_idle", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        model_reset();

        // Reset state.
        sample();
        check("rst_gnt",  32'({m1_gnt, m0_gnt}), 32'd0);
        check("rst_req",  32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        advance();
        rst = 1'b1;

        // m0 line read at 0x1014 with mem_ready always high.
        tbl[0] = '{1'b1, 1'b1, 32'h11, 1'b0, 32'h0,    1'b0, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 1'b1, 32'h22, 1'b1, 32'h1010, 1'b1, 1'b0, 2'd0};
        tbl[2] = '{1'b1, 1'b1, 32'h33, 1'b1, 32'h1014, 1'b1, 1'b0, 2'd1};
        tbl[3] = '{1'b1, 1'b1, 32'h44, 1'b1, 32'h1018, 1'b1, 1'b0, 2'd2};
        tbl[4] = '{1'b1, 1'b1, 32'h55, 1'b1, 32'h101C, 1'b1, 1'b0, 2'd3};
        tbl[5] = '{1'b1, 1'b1, 32'h66, 1'b0, 32'h0,    1'b0, 1'b1, 2'd0};
        tbl[6] = '{1'b0, 1'b1, 32'h77, 1'b0, 32'h0,    1'b0, 1'b0, 2'd0};
        tbl[7] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0,    1'b0, 1'b0, 2'd0};
        m0_addr = 32'h0000_1014;
        for (int i = 0; i < 8; i++) begin
            m0_req = tbl[i].req0; mem_ready = tbl[i].ready; mem_rdata = tbl[i].rd;
            sample();
            check($sformatf("tbl%0d_gnt0", i),   32'(m0_gnt),    32'(tbl[i].gnt0));
            check($sformatf("tbl%0d_addr", i),   mem_addr,       tbl[i].addr);
            check($sformatf("tbl%0d_rvalid", i), 32'(m0_rvalid), 32'(tbl[i].rvalid0));
            check($sformatf("tbl%0d_rdata", i),  rdata,          tbl[i].rvalid0 ? tbl[i].rd : 32'd0);
            check($sformatf("tbl%0d_done0", i),  32'(m0_done),   32'(tbl[i].done0));
            check($sformatf("tbl%0d_beat", i),   32'(beat),      32'(tbl[i].bt));
            advance();
        end

        // Simultaneous requests after reset alternate m0, m1, m0, m1.
        reset_dut();
        m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200; mem_ready = 1;
        ng = 0; prevg = 0;
        for (int i = 0; i < 80 && ng < 4; i++) begin
            sample();
            if ((m0_gnt || m1_gnt) && !prevg) begin order[ng] = int'(m1_gnt); ng++; end
            prevg = m0_gnt || m1_gnt;
            advance();
        end
        wait_idle();
        check("alt_count", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("alt_order%0d", k), 32'(order[k]), 32'(k % 2));

        // m1 write with mem_ready every other cycle.
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_4008;
        bc = 0; gcnt = 0; rv1 = 0; seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (owner == 1) begin mem_ready = (bc % 2 == 1); bc++; end
            else mem_ready = 1'b0;
            m1_wdata = 32'hD000_0000 + 32'(words);
            sample();
            if (m1_gnt) gcnt++;
            if (m1_rvalid) rv1++;
            if (m1_done) seen = 1;
            advance();
        end
        m1_req = 0; m1_we = 0;
        check("wr_done_seen", 32'(seen), 32'd1);
        check("wr_burst_cycles", 32'(gcnt), 32'd8);
        check("wr_no_rvalid", 32'(rv1), 32'd0);
        wait_idle();

        // m1 requests mid m0 burst; m0 drops req at beat 1.
        m0_req = 1; m0_we = 0; m0_addr = 32'h2000; m1_addr = 32'h3000; mem_ready = 1;
        beats = 0; t_done = -1; t_gnt = -1;
        for (int i = 0; i < 40 && t_gnt < 0; i++) begin
            if (owner == 0 && words == 1) begin m0_req = 0; m1_req = 1; end
            sample();
            if (m0_rvalid) beats++;
            if (m0_done) t_done = cyc;
            if (m1_gnt && t_gnt < 0) t_gnt = cyc;
            advance();
        end
        check("m0_beats", 32'(beats), 32'd4);
        check("m1_gnt_gap", 32'(t_gnt - t_done), 32'd2);
        wait_idle();

        // Asynchronous reset at beat 2.
        m0_req = 1; m0_addr = 32'h5000; mem_ready = 1; reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (owner == 0 && words == 2) reached = 1;
            else tick();
        end
        check("reached_beat2", 32'(reached), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_gnt",  32'(m0_gnt),  32'd0);
        check("arst_req",  32'(mem_req), 32'd0);
        check("arst_beat", 32'(beat),    32'd0);
        check("arst_addr", mem_addr,     32'd0);
        check("arst_done", 32'(m0_done), 32'd0);
        model_reset();
        m0_req = 0;
        tick(); tick();
        rst = 1'b1;
        tick();
        m0_req = 1; m0_addr = 32'h6004;
        tick();
        sample();
        check("restart_beat", 32'(beat), 32'd0);
        check("restart_addr", mem_addr,  32'h6000);
        advance();
        wait_idle();

        // mem_ready held low.
        m0_req = 1; m0_addr = 32'h7000; mem_ready = 0; tg = -1; te = -1; td = -1;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (m0_gnt && tg < 0) tg = cyc;
            if (err && te < 0) te = cyc;
            if (m0_done && td < 0) td = cyc;
            advance();
            if (td >= 0) m0_req = 0;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        check("to_err_delay", 32'(te - tg), 32'd8);
        check("to_done_with_err", 32'(td), 32'(te));
`else
        sample();
        check("stall_gnt", 32'(m0_gnt), 32'd1);
        check("stall_req", 32'(mem_req), 32'd1);
        check("stall_no_err", 32'(te < 0 && td < 0), 32'd1);
        advance();
`endif
        wait_idle();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 149) != 0);
            if (!rst) model_reset();
            m0_req    = ($urandom_range(0, 2) != 0);
            m1_req    = ($urandom_range(0, 2) != 0);
            m0_we     = 1'($urandom_range(0, 1));
            m1_we     = 1'($urandom_range(0, 1));
            m0_addr   = $urandom;
            m1_addr   = $urandom;
            m0_wdata  = $urandom;
            m1_wdata  = $urandom;
            mem_rdata = $urandom;
            mem_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
